io_cell_cfg_regs: RTL

APB-programmable configuration register bank that produces the flat `cell_cfg` vector consumed by the SoC IO cell frame. Software writes per-cell shadow registers, then issues a single APPLY so that all pad configurations change on the same clock edge. A sticky LOCK freezes the pad configuration until the next reset. The block sits in the IO subsystem, directly upstream of the IO cell frame, on the peripheral APB.

---
 rtl/io_cell_cfg_regs.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/io_cell_cfg_regs.sv
// io_cell_cfg_regs: APB register bank holding per-cell shadow/active pad
// configuration. Software stages shadows, APPLY moves them all to the
// active copy on one edge, and LOCK freezes everything until reset.

// One IO cell: shadow register plus the active copy feeding the pad.
module io_cell_cfg_slice #(
  parameter int                  W   = 5,
  parameter logic [W-1:0]        RST = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wdata,
  input  logic         apply,
  output logic [W-1:0] shadow,
  output logic [W-1:0] active
);

  // Shadow takes software writes; active only moves on APPLY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= RST;
      active <= RST;
    end else begin
      if (wr_en) shadow <= wdata;
      if (apply) active <= shadow;
    end
  end

endmodule

module io_cell_cfg_regs #(
  parameter int                          IOCELL_CFG_W = 5,
  parameter int                          IOCELL_COUNT = 28,
  parameter int                          APB_AW       = 12,
  parameter int                          APB_DW       = 32,
  parameter logic [IOCELL_CFG_W-1:0]     CFG_RST_VAL  = '0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [APB_AW-1:0]                    paddr,
  input  logic                                 psel,
  input  logic                                 penable,
  input  logic                                 pwrite,
  input  logic [APB_DW-1:0]                    pwdata,
  output logic [APB_DW-1:0]                    prdata,
  output logic                                 pready,
  output logic                                 pslverr,
  output logic [IOCELL_CFG_W*IOCELL_COUNT-1:0] cell_cfg,
  output logic                                 cfg_locked,
  output logic                                 cfg_pending
);

  localparam int                WORD_W     = APB_AW - 2;
  localparam logic [APB_AW-1:0] SHADOW_END = APB_AW'(4 * IOCELL_COUNT);
  localparam logic [APB_AW-1:0] CTRL_ADDR  = APB_AW'('h100);
  localparam logic [APB_AW-1:0] STAT_ADDR  = APB_AW'('h104);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e state_q, state_d;
  logic   commit;
  logic   locked_q;

  logic [IOCELL_COUNT-1:0][IOCELL_CFG_W-1:0] shadow;
  logic [IOCELL_COUNT-1:0][IOCELL_CFG_W-1:0] active;

  logic [WORD_W-1:0] word;
  logic              aligned, hit_shadow, hit_ctrl, hit_stat, err;
  logic              wr_shadow, do_apply, do_lock;
  logic [APB_DW-1:0] rdata;

  // Upper write-data bits carry no meaning for any register.
  logic unused_pwdata;
  assign unused_pwdata = ^pwdata[APB_DW-1:IOCELL_CFG_W];

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Setup moves to WAIT; the access cycle in WAIT commits and goes to RESP.
  // Losing psel in WAIT aborts without touching any state.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (psel) state_d = WAIT;
      WAIT: begin
        if (!psel) state_d = IDLE;
        else if (penable) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address decode and error classification.
  always_comb begin
    word       = paddr[APB_AW-1:2];
    aligned    = (paddr[1:0] == 2'b00);
    hit_shadow = aligned && (paddr < SHADOW_END);
    hit_ctrl   = (paddr == CTRL_ADDR);
    hit_stat   = (paddr == STAT_ADDR);
    err        = !(hit_shadow || hit_ctrl || hit_stat)
              || (pwrite && hit_stat)
              || (pwrite && locked_q && (hit_shadow || hit_ctrl));
    wr_shadow  = commit && !err && pwrite && hit_shadow;
    do_apply   = commit && !err && pwrite && hit_ctrl && pwdata[0];
    do_lock    = commit && !err && pwrite && hit_ctrl && pwdata[1];
  end

  // Read mux from current register state; unused bits read as zero.
  always_comb begin
    rdata = '0;
    if (hit_shadow) begin
      for (int i = 0; i < IOCELL_COUNT; i++)
        if (word == WORD_W'(i)) rdata = APB_DW'(shadow[i]);
    end else if (hit_ctrl) begin
      rdata = APB_DW'({locked_q, 1'b0});
    end else if (hit_stat) begin
      rdata = APB_DW'({locked_q, cfg_pending});
    end
  end

  for (genvar i = 0; i < IOCELL_COUNT; i++) begin : g_cell
    io_cell_cfg_slice #(
      .W   (IOCELL_CFG_W),
      .RST (CFG_RST_VAL)
    ) u_slice (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_shadow && (word == WORD_W'(i))),
      .wdata   (pwdata[IOCELL_CFG_W-1:0]),
      .apply   (do_apply),
      .shadow  (shadow[i]),
      .active  (active[i])
    );
  end

  // Sticky lock plus the registered APB response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q <= 1'b0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
    end else begin
      if (do_lock) locked_q <= 1'b1;
      pready  <= commit;
      pslverr <= commit && err;
      prdata  <= (commit && !err && !pwrite) ? rdata : '0;
    end
  end

  assign cell_cfg    = active;
  assign cfg_locked  = locked_q;
  assign cfg_pending = (shadow != active);

endmodule
